muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 10 +
 rtl/muldiv_step.sv | 26 ++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and FSM state type shared by the multiply/divide unit
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SIGN} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide
// Ports: div selects divide; r_i/q_i current partial remainder-or-high / quotient-or-low,
//        b multiplicand-or-divisor magnitude; r_o/q_o next values.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  // The partial remainder always stays below the divisor, so it fits WIDTH bits
  // and the shifted value fits WIDTH+1; diff's top bit is the borrow.
  always_comb begin
    sum  = {1'b0, r_i} + (q_i[0] ? {1'b0, b} : '0);
    sh   = {r_i, q_i[WIDTH-1]};
    diff = {1'b0, sh} - {2'b0, b};
    r_o  = div ? (diff[WIDTH+1] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    q_o  = div ? {q_i[WIDTH-2:0], ~diff[WIDTH+1]} : {sum[0], q_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and MTHI/MTLO
// Ports: clk, reset (sync, active high); start/op/in_a/in_b issue; flush aborts;
//        busy while running, done/div_by_zero pulse with a new result; hi/lo registers.
// Build option: define MULDIV_ZERO_SKIP_EN to bypass RUN for zero-operand multiplies
//               and divide-by-zero.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, qn_q, qn_d, rn_q, rn_d, dz_q, dz_d, done_q, done_d, dzo_q, dzo_d;
  logic [WIDTH-1:0] r_c [0:BITS_PER_CYCLE];
  logic [WIDTH-1:0] q_c [0:BITS_PER_CYCLE];
  logic [WIDTH-1:0] a_m, b_m;
  logic [2*WIDTH-1:0] prod;
  logic idle_ok, go, sa, sb, b_zero, skip, sign_w;
  assign r_c[0] = r_q;
  assign q_c[0] = q_q;
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div (div_q),
      .r_i (r_c[g]),
      .q_i (q_c[g]),
      .b   (b_q),
      .r_o (r_c[g+1]),
      .q_o (q_c[g+1])
    );
  end
  // Operand decode; the magnitude of the most negative value is 2^(WIDTH-1),
  // which is exact as an unsigned WIDTH-bit number.
  always_comb begin
    idle_ok = start && !flush && state_q == ST_IDLE;
    go      = idle_ok && !op[2];
    sa      = !op[0] && in_a[WIDTH-1];
    sb      = !op[0] && in_b[WIDTH-1];
    a_m     = sa ? -in_a : in_a;
    b_m     = sb ? -in_b : in_b;
    b_zero  = in_b == '0;
`ifdef MULDIV_ZERO_SKIP_EN
    skip    = op[1] ? b_zero : (b_zero || in_a == '0);
`else
    skip    = 1'b0;
`endif
  end
  always_comb begin
    state_d = flush ? ST_IDLE :
              go ? (skip ? ST_SIGN : ST_RUN) :
              (state_q == ST_RUN && cnt_q == '0) ? ST_SIGN :
              (state_q == ST_SIGN) ? ST_IDLE : state_q;
  end
  // A skipped operation preloads the magnitudes the full iteration would reach:
  // zero product, or divide-by-zero quotient all ones with remainder |a|.
  always_comb begin
    cnt_d  = state_q == ST_RUN ? cnt_q - CW'(1) : CW'(N - 1);
    r_d    = go ? ((skip && op[1]) ? a_m : '0) : state_q == ST_RUN ? r_c[BITS_PER_CYCLE] : r_q;
    q_d    = go ? (skip ? (op[1] ? '1 : '0) : a_m) : state_q == ST_RUN ? q_c[BITS_PER_CYCLE] : q_q;
    b_d    = go ? b_m : b_q;
    div_d  = go ? op[1] : div_q;
    qn_d   = go ? ((sa ^ sb) && !(op[1] && b_zero)) : qn_q;
    rn_d   = go ? sa : rn_q;
    dz_d   = go ? (op[1] && b_zero) : dz_q;
    prod   = qn_q ? -{r_q, q_q} : {r_q, q_q};
    sign_w = state_q == ST_SIGN && !flush;
    hi_d   = sign_w ? (div_q ? (rn_q ? -r_q : r_q) : prod[2*WIDTH-1:WIDTH]) :
             (idle_ok && op == OP_MTHI) ? in_a : hi_q;
    lo_d   = sign_w ? (div_q ? (qn_q ? -q_q : q_q) : prod[WIDTH-1:0]) :
             (idle_ok && op == OP_MTLO) ? in_a : lo_q;
    done_d = sign_w;
    dzo_d  = sign_w && dz_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      qn_q    <= 1'b0;
      rn_q    <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      div_q   <= div_d;
      qn_q    <= qn_d;
      rn_q    <= rn_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dzo_q   <= dzo_d;
    end
  end
  always_comb begin
    busy        = state_q != ST_IDLE;
    done        = done_q;
    div_by_zero = dzo_q;
    hi          = hi_q;
    lo          = lo_q;
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;
  import muldiv_pkg::*;
  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic [2:0] op = 3'b111;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic busy, done, dz;
  logic [31:0] hi, lo;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
`ifdef MULDIV_ZERO_SKIP_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = 34;
`endif

  muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_dz"}, 32'(dz), 32'(e.dz));
        chk({e.name, "_cyc"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int t);
    step(1);
    start = 1'b1;
    op = o;
    in_a = a;
    in_b = b;
    t = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic run(input string n, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic ed, input int lat);
    int t;
    issue(o, a, b, t);
    sb.push_back('{n, eh, el, ed, t + lat});
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 100) begin
      step(1);
      k++;
    end
    chk("drain_timeout", 32'(k < 100), 32'd1);
    step(2);
  endtask

  initial begin
    int t;
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    step(3);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, t);
    sb.push_back('{"multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, t + 34});
    for (int k = 1; k <= 34; k++) begin
      if (k > 1) step(1);
      chk($sformatf("busy_t%0d", k), 32'(busy), 32'(k <= 33));
    end
    drain();

    run("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
    drain();
    run("multu_mid", OP_MULTU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0, 34);
    drain();
    run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    drain();
    run("divu", OP_DIVU, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0, 34);
    drain();
    run("div_min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
    drain();
    run("div_negb", OP_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, 34);
    drain();
    run("divu_zero", OP_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b1, DZ_LAT);
    chk("dz_busy", 32'(busy), 32'd1);
    drain();
    run("div_zero", OP_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, DZ_LAT);
    drain();

    issue(OP_MTHI, 32'h11, 32'h0, t);
    issue(OP_MTLO, 32'h22, 32'h0, t);
    chk("mt_hi", hi, 32'h11);
    chk("mt_lo", lo, 32'h22);
    issue(OP_MULTU, 32'h3, 32'h4, t);
    step(9);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    step(40);
    chk("flush_hi", hi, 32'h11);
    chk("flush_lo", lo, 32'h22);

    run("ignored_start", OP_MULTU, 32'h2, 32'h3, 32'h0, 32'h6, 1'b0, 34);
    step(4);
    start = 1'b1;
    op = OP_DIVU;
    in_a = 32'd100;
    in_b = 32'd7;
    step(1);
    start = 1'b0;
    drain();
    step(40);

    issue(OP_MTHI, 32'h1234, 32'h0, t);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_done", 32'(done), 32'd0);
    step(1);
    chk("mthi_done2", 32'(done), 32'd0);
    flush = 1'b1;
    issue(OP_MTHI, 32'hBEEF, 32'h0, t);
    flush = 1'b0;
    chk("mthi_flush_hi", hi, 32'h1234);
    issue(3'b110, 32'hDEAD, 32'hBEEF, t);
    chk("nop_busy", 32'(busy), 32'd0);
    chk("nop_hi", hi, 32'h1234);
    chk("nop_lo", lo, 32'h6);

    issue(OP_DIV, 32'd100, 32'd7, t);
    step(19);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_dz", 32'(dz), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    step(40);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
